// File: rtl/bp_nonsynth_trace_pkg.sv
// Shared types for the trace replay engines: opcodes, engine states and a
// macro that declares the packed ROM word for a given channel/payload width.
`ifndef BP_NONSYNTH_TRACE_PKG_SV
`define BP_NONSYNTH_TRACE_PKG_SV

`define BP_DECLARE_TRACE_ROM_WORD_S(chan_width_mp, payload_width_mp) \
  typedef struct packed {                                             \
    logic [3:0]                  op;                                  \
    logic [chan_width_mp-1:0]    chan;                                \
    logic [payload_width_mp-1:0] payload;                             \
  } bp_trace_rom_word_s

package bp_nonsynth_trace_pkg;

  typedef enum logic [3:0] {
    e_op_nop    = 4'd0,
    e_op_send   = 4'd1,
    e_op_recv   = 4'd2,
    e_op_wait   = 4'd3,
    e_op_done   = 4'd4,
    e_op_finish = 4'd5
  } bp_trace_op_e;

  typedef enum logic [1:0] {
    e_exec = 2'd0,
    e_wait = 2'd1,
    e_done = 2'd2,
    e_halt = 2'd3
  } bp_trace_state_e;

endpackage

`endif

// File: rtl/bp_nonsynth_trace_watchdog.sv
// Stall watchdog: counts enabled cycles an op stays pending without advancing
// and raises a sticky timeout flag when timeout_p is reached (0 disables it).
module bp_nonsynth_trace_watchdog #(
  parameter int timeout_p = 4096
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic pending_i,
  input  logic advance_i,
  output logic fire_o,
  output logic timeout_o
);

  if (timeout_p == 0) begin : g_off
    assign fire_o    = 1'b0;
    assign timeout_o = 1'b0;
  end else begin : g_on
    localparam int cnt_width_lp = $clog2(timeout_p + 1);

    logic [cnt_width_lp-1:0] cnt_reg;
    logic                    timeout_reg;

    // Fires on the cycle that would make the stall count reach timeout_p.
    assign fire_o    = en_i & pending_i & ~advance_i
                     & (cnt_reg == cnt_width_lp'(timeout_p - 1));
    assign timeout_o = timeout_reg;

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        cnt_reg     <= '0;
        timeout_reg <= 1'b0;
      end else if (en_i) begin
        if (!pending_i || advance_i)
          cnt_reg <= '0;
        else if (!fire_o)
          cnt_reg <= cnt_reg + 1'b1;
        if (fire_o)
          timeout_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bp_nonsynth_trace_replay_mc.sv
// Multi-channel ROM-driven trace replay engine (send/recv/wait/done ops).
// Define BP_TRACE_REPLAY_STOP_ON_MISMATCH_EN to halt on the first recv mismatch.
module bp_nonsynth_trace_replay_mc
  import bp_nonsynth_trace_pkg::*;
#(
  parameter  int payload_width_p  = 64,
  parameter  int num_chan_p       = 2,
  parameter  int rom_addr_width_p = 8,
  parameter  int wait_width_p     = 16,
  parameter  int timeout_p        = 4096,
  parameter  int err_cnt_width_p  = 8,
  localparam int chan_width_lp    = (num_chan_p > 1) ? $clog2(num_chan_p) : 1,
  localparam int rom_width_lp     = 4 + chan_width_lp + payload_width_p
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  en_i,
  input  logic [num_chan_p-1:0]                 v_i,
  input  logic [num_chan_p*payload_width_p-1:0] data_i,
  output logic [num_chan_p-1:0]                 ready_and_o,
  output logic [num_chan_p-1:0]                 v_o,
  output logic [payload_width_p-1:0]            data_o,
  input  logic [num_chan_p-1:0]                 yumi_i,
  output logic [rom_addr_width_p-1:0]           rom_addr_o,
  input  logic [rom_width_lp-1:0]               rom_data_i,
  output logic                                  done_o,
  output logic                                  error_o,
  output logic                                  timeout_o,
  output logic [err_cnt_width_p-1:0]            mismatch_cnt_o
);

`ifdef BP_TRACE_REPLAY_STOP_ON_MISMATCH_EN
  localparam bit stop_on_mismatch_lp = 1'b1;
`else
  localparam bit stop_on_mismatch_lp = 1'b0;
`endif

  `BP_DECLARE_TRACE_ROM_WORD_S(chan_width_lp, payload_width_p);

  bp_trace_rom_word_s rom_word;
  assign rom_word = rom_data_i;

  bp_trace_state_e               state_reg, state_next;
  logic [rom_addr_width_p-1:0]   addr_reg, addr_next;
  logic [wait_width_p-1:0]       wait_reg, wait_next;
  logic                          done_reg, done_next;
  logic                          error_reg, error_next;
  logic [err_cnt_width_p-1:0]    mm_reg, mm_next;

  logic [payload_width_p-1:0] rx_data [num_chan_p];
  logic [num_chan_p-1:0]      chan_sel;
  logic [payload_width_p-1:0] sel_data;
  logic [wait_width_p-1:0]    wait_load;
  logic chan_ok, is_exec, is_send, is_recv;
  logic send_hit, recv_hit, op_pending, op_hit, mismatch, stray_yumi;
  logic advance, halt, wd_fire;

  for (genvar gi = 0; gi < num_chan_p; gi++) begin : g_chan
    assign rx_data[gi]  = data_i[gi*payload_width_p +: payload_width_p];
    assign chan_sel[gi] = (rom_word.chan == chan_width_lp'(gi));
  end

  always_comb begin
    sel_data = '0;
    for (int c = 0; c < num_chan_p; c++)
      if (chan_sel[c]) sel_data = rx_data[c];
  end

  assign chan_ok   = (32'(rom_word.chan) < num_chan_p);
  assign wait_load = rom_word.payload[wait_width_p-1:0];
  assign is_exec   = en_i && (state_reg == e_exec);
  assign is_send   = is_exec && (rom_word.op == e_op_send) && chan_ok;
  assign is_recv   = is_exec && (rom_word.op == e_op_recv) && chan_ok;

  assign v_o         = is_send ? chan_sel : '0;
  assign ready_and_o = is_recv ? chan_sel : '0;
  assign data_o      = rom_word.payload;

  assign send_hit   = is_send && |(yumi_i & chan_sel);
  assign recv_hit   = is_recv && |(v_i & chan_sel);
  assign op_pending = is_send | is_recv;
  assign op_hit     = send_hit | recv_hit;
  assign mismatch   = recv_hit && (sel_data != rom_word.payload);
  // A consume on any channel we are not currently offering is a DUT protocol bug.
  assign stray_yumi = en_i && |(yumi_i & ~v_o);

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wait_next  = wait_reg;
    done_next  = done_reg;
    error_next = error_reg;
    mm_next    = mm_reg;
    advance    = 1'b0;
    halt       = 1'b0;

    if (en_i) begin
      case (state_reg)
        e_exec: begin
          case (rom_word.op)
            e_op_nop: advance = 1'b1;
            e_op_send, e_op_recv: begin
              if (!chan_ok)
                halt = 1'b1;
              else if (op_hit) begin
                if (mismatch && stop_on_mismatch_lp) halt = 1'b1;
                else                                 advance = 1'b1;
              end
            end
            e_op_wait: begin
              if (wait_load == '0)
                advance = 1'b1;
              else begin
                wait_next  = wait_load;
                state_next = e_wait;
              end
            end
            e_op_done, e_op_finish: begin
              done_next  = 1'b1;
              state_next = e_done;
            end
            default: halt = 1'b1;
          endcase
        end
        e_wait: begin
          wait_next = wait_reg - 1'b1;
          if (wait_reg == wait_width_p'(1)) advance = 1'b1;
        end
        default: ;
      endcase
    end

    // Running off the end of the ROM is a trace bug, not a wrap.
    if (advance) begin
      if (&addr_reg)
        halt = 1'b1;
      else begin
        addr_next  = addr_reg + 1'b1;
        state_next = e_exec;
      end
    end
    if (wd_fire) halt = 1'b1;
    if (halt) begin
      error_next = 1'b1;
      state_next = e_halt;
    end
    if (mismatch) begin
      error_next = 1'b1;
      if (~&mm_reg) mm_next = mm_reg + 1'b1;
    end
    if (stray_yumi) error_next = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= e_exec;
      addr_reg  <= '0;
      wait_reg  <= '0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      mm_reg    <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wait_reg  <= wait_next;
      done_reg  <= done_next;
      error_reg <= error_next;
      mm_reg    <= mm_next;
    end
  end

  bp_nonsynth_trace_watchdog #(
    .timeout_p(timeout_p)
  ) watchdog (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .en_i     (en_i),
    .pending_i(op_pending),
    .advance_i(op_hit),
    .fire_o   (wd_fire),
    .timeout_o(timeout_o)
  );

  assign rom_addr_o     = addr_reg;
  assign done_o         = done_reg;
  assign error_o        = error_reg;
  assign mismatch_cnt_o = mm_reg;

endmodule

// File: tb/tb_bp_nonsynth_trace_replay_mc.sv
// Bench for bp_nonsynth_trace_replay_mc: table of single-op traces plus
// hand-written multi-cycle sequences; sends are checked against a scoreboard.
module tb_bp_nonsynth_trace_replay_mc;
  import bp_nonsynth_trace_pkg::*;

  localparam int PW = 64;
  localparam int NC = 4;
  localparam int AW = 8;
  localparam int CW = 2;
  localparam int RW = 4 + CW + PW;
  localparam int TO = 16;
  localparam int EW = 8;
`ifdef BP_TRACE_REPLAY_STOP_ON_MISMATCH_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic             clk;
  logic             reset_i;
  logic             en_i;
  logic [NC-1:0]    v_i;
  logic [NC*PW-1:0] data_i;
  logic [NC-1:0]    ready_and_o;
  logic [NC-1:0]    v_o;
  logic [PW-1:0]    data_o;
  logic [NC-1:0]    yumi_i;
  logic [AW-1:0]    rom_addr_o;
  logic [RW-1:0]    rom_data_i;
  logic             done_o;
  logic             error_o;
  logic             timeout_o;
  logic [EW-1:0]    mismatch_cnt_o;

  bp_nonsynth_trace_replay_mc #(
    .payload_width_p(PW), .num_chan_p(NC), .rom_addr_width_p(AW),
    .wait_width_p(16), .timeout_p(TO), .err_cnt_width_p(EW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .v_i(v_i), .data_i(data_i),
    .ready_and_o(ready_and_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i), .done_o(done_o),
    .error_o(error_o), .timeout_o(timeout_o), .mismatch_cnt_o(mismatch_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Trace ROM and DUT-side model configuration
  logic [RW-1:0] rom [256];
  logic [PW-1:0] rsp_data [NC];
  int            rsp_dly [NC];
  logic          loopback;
  logic [NC-1:0] ymask;
  logic [NC-1:0] yforce;

  assign rom_data_i = rom[rom_addr_o];
  assign yumi_i     = (v_o & ymask) | yforce;

  int            rdy_cnt [NC];
  logic [PW-1:0] loop_data [NC];
  logic [NC-1:0] loop_v;

  always_ff @(posedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (reset_i || !ready_and_o[c] || v_i[c]) rdy_cnt[c] <= 0;
      else                                      rdy_cnt[c] <= rdy_cnt[c] + 1;
      if (reset_i) loop_v[c] <= 1'b0;
      else if (v_o[c] && yumi_i[c]) begin
        loop_v[c]    <= 1'b1;
        loop_data[c] <= data_o;
      end
    end
  end

  always_comb begin
    v_i    = '0;
    data_i = '0;
    for (int c = 0; c < NC; c++) begin
      data_i[c*PW +: PW] = loopback ? loop_data[c] : rsp_data[c];
      v_i[c] = ready_and_o[c] && (rdy_cnt[c] >= rsp_dly[c]) && (!loopback || loop_v[c]);
    end
  end

  typedef struct packed {
    logic [CW-1:0] chan;
    logic [PW-1:0] data;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    string       name;
    logic [3:0]  op;
    int          chan;
    logic [63:0] pl;
    logic [63:0] rsp;
    int          dly;
    logic [3:0]  ym;
    logic [3:0]  yf;
    bit          e_done;
    bit          e_err;
    int          e_mm;
    bit          e_to;
    int          e_cyc;
  } vec_t;
  vec_t vecs[$];

  int n_chk = 0;
  int n_bad = 0;
  logic [NC-1:0] seen_v, seen_r;

  function automatic logic [RW-1:0] word(input logic [3:0] op, input int chan,
                                          input logic [PW-1:0] pl);
    logic [31:0] c;
    c = chan;
    return {op, c[CW-1:0], pl};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    sb_t e;
    @(negedge clk);
    if (!reset_i) begin
      seen_v |= v_o;
      seen_r |= ready_and_o;
      if (|(v_o & yumi_i)) begin
        if (sbq.size() == 0)
          chk("sb_unexpected_send", 64'(v_o & yumi_i), 64'(0));
        else begin
          e = sbq.pop_front();
          chk("sb_chan", 64'(v_o & yumi_i), 64'(4'b0001) << e.chan);
          chk("sb_data", data_o, e.data);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < 256; i++) rom[i] = word(e_op_done, 0, '0);
    for (int c = 0; c < NC; c++) begin
      rsp_data[c] = '0;
      rsp_dly[c]  = 0;
    end
    loopback = 1'b0;
    ymask    = '1;
    yforce   = '0;
    sbq.delete();
  endtask

  task automatic start_run();
    en_i    = 1'b0;
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    en_i    = 1'b1;
    seen_v  = '0;
    seen_r  = '0;
  endtask

  // Steps until done_o is seen; returns -1 if the budget expires first.
  task automatic run_from(input int start, input int budget, output int cyc);
    cyc = start;
    while (cyc < budget) begin
      tick();
      cyc++;
      if (done_o) break;
    end
    if (!done_o) cyc = -1;
  endtask

  task automatic add_vec(input string name, input logic [3:0] op, input int chan,
                         input logic [63:0] pl, input logic [63:0] rsp, input int dly,
                         input logic [3:0] ym, input logic [3:0] yf, input bit e_done,
                         input bit e_err, input int e_mm, input bit e_to, input int e_cyc);
    vec_t v;
    v = '{name, op, chan, pl, rsp, dly, ym, yf, e_done, e_err, e_mm, e_to, e_cyc};
    vecs.push_back(v);
  endtask

  initial begin
    int cyc;
    reset_i = 1'b1;
    en_i    = 1'b0;
    clear_cfg();

    // Reset state
    start_run();
    chk("rst_addr", 64'(rom_addr_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_err", 64'(error_o), 64'(0));
    chk("rst_to", 64'(timeout_o), 64'(0));
    chk("rst_mm", 64'(mismatch_cnt_o), 64'(0));
    $display("reset: addr=%0d done=%0b err=%0b", rom_addr_o, done_o, error_o);

    //       name        op           ch payload   rsp     dly ymask  yforce  done   err  mm to cycles
    add_vec("nop",       e_op_nop,    0, 64'h0,    64'h0,  0, 4'hF, 4'h0,   1,     0,   0, 0, 2);
    add_vec("send1",     e_op_send,   1, 64'h1234, 64'h0,  0, 4'hF, 4'h0,   1,     0,   0, 0, 2);
    add_vec("recv2",     e_op_recv,   2, 64'hBEEF, 64'hBEEF,0,4'hF, 4'h0,   1,     0,   0, 0, 2);
    add_vec("recv3_dly", e_op_recv,   3, 64'h22,   64'h22, 10, 4'hF, 4'h0,  1,     0,   0, 0, 12);
    add_vec("recv_mm",   e_op_recv,   1, 64'h5,    64'h6,  0, 4'hF, 4'h0,   !STOP, 1,   1, 0, STOP ? -1 : 2);
    add_vec("wait0",     e_op_wait,   0, 64'h0,    64'h0,  0, 4'hF, 4'h0,   1,     0,   0, 0, 2);
    add_vec("wait3",     e_op_wait,   0, 64'h3,    64'h0,  0, 4'hF, 4'h0,   1,     0,   0, 0, 5);
    add_vec("illegal",   4'hF,        0, 64'h0,    64'h0,  0, 4'hF, 4'h0,   0,     1,   0, 0, -1);
    add_vec("send_stall",e_op_send,   0, 64'h9,    64'h0,  0, 4'h0, 4'h0,   0,     1,   0, 1, -1);
    add_vec("finish",    e_op_finish, 0, 64'h0,    64'h0,  0, 4'hF, 4'h0,   1,     0,   0, 0, 1);
    add_vec("stray_yumi",e_op_nop,    0, 64'h0,    64'h0,  0, 4'hF, 4'h4,   1,     1,   0, 0, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      clear_cfg();
      rom[0] = word(vecs[i].op, vecs[i].chan, vecs[i].pl);
      rsp_data[vecs[i].chan] = vecs[i].rsp;
      rsp_dly[vecs[i].chan]  = vecs[i].dly;
      ymask  = vecs[i].ym;
      yforce = vecs[i].yf;
      if (vecs[i].op == e_op_send && vecs[i].ym[vecs[i].chan])
        sbq.push_back('{chan: CW'(vecs[i].chan), data: vecs[i].pl});
      start_run();
      run_from(0, 40, cyc);
      chk({vecs[i].name, "_cyc"},  64'(cyc), 64'(vecs[i].e_cyc));
      chk({vecs[i].name, "_done"}, 64'(done_o), 64'(vecs[i].e_done));
      chk({vecs[i].name, "_err"},  64'(error_o), 64'(vecs[i].e_err));
      chk({vecs[i].name, "_mm"},   64'(mismatch_cnt_o), 64'(vecs[i].e_mm));
      chk({vecs[i].name, "_to"},   64'(timeout_o), 64'(vecs[i].e_to));
      chk({vecs[i].name, "_sb_left"}, 64'(sbq.size()), 64'(0));
      $display("vec %s: cyc=%0d done=%0b err=%0b mm=%0d to=%0b", vecs[i].name, cyc,
               done_o, error_o, mismatch_cnt_o, timeout_o);
    end

    // Loopback send/recv then done
    clear_cfg();
    rom[0] = word(e_op_send, 0, 64'hA5);
    rom[1] = word(e_op_recv, 0, 64'hA5);
    rom[2] = word(e_op_done, 0, '0);
    loopback = 1'b1;
    sbq.push_back('{chan: 2'd0, data: 64'hA5});
    start_run();
    run_from(0, 40, cyc);
    chk("loop_cyc", 64'(cyc), 64'(3));
    chk("loop_err", 64'(error_o), 64'(0));
    chk("loop_mm", 64'(mismatch_cnt_o), 64'(0));
    chk("loop_sb_left", 64'(sbq.size()), 64'(0));
    $display("loopback: cyc=%0d err=%0b mm=%0d", cyc, error_o, mismatch_cnt_o);

    // Cross-channel: send ch2, delayed recv ch3
    clear_cfg();
    rom[0] = word(e_op_send, 2, 64'h11);
    rom[1] = word(e_op_recv, 3, 64'h22);
    rom[2] = word(e_op_done, 0, '0);
    rsp_data[3] = 64'h22;
    rsp_dly[3]  = 10;
    sbq.push_back('{chan: 2'd2, data: 64'h11});
    start_run();
    run_from(0, 40, cyc);
    chk("xch_cyc", 64'(cyc), 64'(13));
    chk("xch_seen_v", 64'(seen_v), 64'(4'b0100));
    chk("xch_seen_r", 64'(seen_r), 64'(4'b1000));
    chk("xch_err", 64'(error_o), 64'(0));
    $display("cross-chan: cyc=%0d v=%b r=%b err=%0b", cyc, seen_v, seen_r, error_o);

    // Wait 20, without and with an en_i gap of 5 cycles
    clear_cfg();
    rom[0] = word(e_op_wait, 0, 64'd20);
    start_run();
    run_from(0, 60, cyc);
    chk("wait20_cyc", 64'(cyc), 64'(22));
    $display("wait20: cyc=%0d", cyc);
    start_run();
    cyc = 0;
    repeat (5) begin tick(); cyc++; end
    chk("wait20_early_done", 64'(done_o), 64'(0));
    en_i = 1'b0;
    repeat (5) begin tick(); cyc++; end
    en_i = 1'b1;
    run_from(cyc, 60, cyc);
    chk("wait20_en_cyc", 64'(cyc), 64'(27));
    $display("wait20 en gap: cyc=%0d", cyc);

    // Watchdog fires on the 16th stalled cycle
    clear_cfg();
    rom[0] = word(e_op_send, 0, 64'h77);
    ymask = '0;
    start_run();
    repeat (15) tick();
    chk("wd_before", 64'(timeout_o), 64'(0));
    tick();
    chk("wd_to", 64'(timeout_o), 64'(1));
    chk("wd_err", 64'(error_o), 64'(1));
    chk("wd_v", 64'(v_o), 64'(0));
    repeat (3) tick();
    chk("wd_addr", 64'(rom_addr_o), 64'(0));
    $display("watchdog: to=%0b err=%0b v=%b addr=%0d", timeout_o, error_o, v_o, rom_addr_o);

    // Reset in the middle of a pending send
    clear_cfg();
    rom[0] = word(e_op_nop, 0, '0);
    rom[1] = word(e_op_nop, 0, '0);
    rom[2] = word(e_op_send, 1, 64'h33);
    ymask = '0;
    start_run();
    tick();
    tick();
    chk("mid_addr", 64'(rom_addr_o), 64'(2));
    chk("mid_v", 64'(v_o), 64'(4'b0010));
    reset_i = 1'b1;
    tick();
    chk("mid_rst_addr", 64'(rom_addr_o), 64'(0));
    chk("mid_rst_v", 64'(v_o), 64'(0));
    reset_i = 1'b0;
    $display("reset mid-send: addr=%0d v=%b", rom_addr_o, v_o);

    // Running off the last ROM address halts instead of wrapping
    clear_cfg();
    for (int i = 0; i < 256; i++) rom[i] = word(e_op_nop, 0, '0);
    start_run();
    repeat (255) tick();
    chk("wrap_addr_last", 64'(rom_addr_o), 64'(255));
    chk("wrap_err_before", 64'(error_o), 64'(0));
    tick();
    chk("wrap_err", 64'(error_o), 64'(1));
    repeat (3) tick();
    chk("wrap_addr_frozen", 64'(rom_addr_o), 64'(255));
    chk("wrap_done", 64'(done_o), 64'(0));
    $display("addr wrap: addr=%0d err=%0b", rom_addr_o, error_o);

    // Mismatch counter over a ROM full of mismatching recvs
    clear_cfg();
    for (int i = 0; i < 256; i++) rom[i] = word(e_op_recv, 0, 64'h0);
    rsp_data[0] = 64'h1;
    start_run();
`ifdef BP_TRACE_REPLAY_STOP_ON_MISMATCH_EN
    repeat (4) tick();
    chk("stop_mm", 64'(mismatch_cnt_o), 64'(1));
    chk("stop_addr", 64'(rom_addr_o), 64'(0));
    chk("stop_err", 64'(error_o), 64'(1));
    $display("stop on mismatch: mm=%0d addr=%0d", mismatch_cnt_o, rom_addr_o);
`else
    repeat (254) tick();
    chk("sat_mm_254", 64'(mismatch_cnt_o), 64'(254));
    repeat (2) tick();
    chk("sat_mm_256", 64'(mismatch_cnt_o), 64'(255));
    chk("sat_err", 64'(error_o), 64'(1));
    $display("saturation: mm=%0d err=%0b", mismatch_cnt_o, error_o);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
